clk_en_gen: RTL
===============

# clk_en_gen

Parametrised clock-enable generator for the emulation core. It derives a fractional-rate base tick from the system clock with a phase accumulator. It fans that tick out into NUM_CH phase-aligned power-of-two sub-rate enables, e.g. 65.536 kHz and 32.768 kHz for the CPU `clk_2x_en`/`clk_en`. It adds pause, resync and fast-forward speed multipliers, and replaces the fixed counter divider used in sim tops.

## Interface
- CLK_HZ, 32'd6553600 — system clock frequency in Hz (integer).
- BASE_HZ, 32'd65536 — base tick rate at 1x speed, in Hz.
- NUM_CH, 2 — number of enable outputs; en[i] rate = base / 2^i; NUM_CH ≥ 1.
- ACC_W, 32 — accumulator width; must hold CLK_HZ + (BASE_HZ << 3) − 1 (elaboration assertion).
- clk  input  1  system clock, all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- pause  input  1  level; freezes accumulator and channel counter, suppresses all enables.
- resync  input  1  single-cycle pulse; realigns phase (clears accumulator and counter).
- speed  input  2  fast-forward select 0..3 = 1x/2x/4x/8x (see Configuration).
- en  output  NUM_CH  registered single-cycle enables; en[0] is the base tick.
- tick_cnt  output  NUM_CH-1 (min 1)  free-running base-tick counter, for debug/alignment.

## Operation
- inc = BASE_HZ << speed (ACC_W bits). Each cycle while not paused: sum = acc + inc.
  - If sum ≥ CLK_HZ: acc ← sum − CLK_HZ and a base tick fires.
  - Otherwise acc ← sum.
- Long-term base rate is exactly BASE_HZ·2^speed with no cumulative error. Intervals dither between floor and ceil of CLK_HZ/inc.
- On a base tick:
  - en[i] ← 1 iff tick_cnt[i-1:0] == 0 (en[0] always).
  - tick_cnt ← tick_cnt + 1, wrapping modulo 2^(NUM_CH-1).
- Every en[i] pulse coincides with an en[i-1] pulse. All channels fire together on tick_cnt == 0.
- pause = 1: acc, tick_cnt held; en = 0. Release resumes from the held phase; no tick is lost or duplicated.
- resync = 1: acc ← 0, tick_cnt ← 0, en ← 0 that cycle. Resync takes priority over pause and over a coinciding tick.
- Speed change applies to the sum of the same cycle. Accumulator phase and tick_cnt are preserved.

## Timing
- Reset: acc = 0, tick_cnt = 0, en = 0.
- en is registered and asserted exactly one clk cycle per tick. It never stays high two consecutive cycles, which the CLK_HZ ≥ 16·BASE_HZ requirement guarantees (assertion).
- First tick after reset or resync: en[NUM_CH-1:0] all high on cycle N = ceil(CLK_HZ/inc) after the release edge/pulse.
- Reset asserted mid-operation clears en combinationally-async (flop reset); no partial pulse completes.
- Simultaneous pause and resync: state cleared and held at 0 until pause deasserts.

## Configuration
- CLK_EN_FAST_FORWARD_EN defined: speed input honoured as above.
- Undefined: speed is ignored and inc is the constant BASE_HZ. Shift logic and the 8x width term in the ACC_W assertion are removed. The port remains for interface stability.

## Structure
- Package clk_en_pkg:
  - speed_t enum (SPEED_1X, SPEED_2X, SPEED_4X, SPEED_8X).
  - Function acc_width(clk_hz, base_hz) for the minimum legal ACC_W.
  - MAX_SPEED_SHIFT = 3.
- Sub-module frac_tick: phase accumulator with pause/resync, emitting the base tick. clk_en_gen wraps it with the channel counter and output registers.

## Test plan
- CLK_HZ=100, BASE_HZ=10, NUM_CH=2, speed=0 -> en[0] every 10 cycles, first at cycle 10; en[1] at ticks 0,2,4.
- CLK_HZ=100, BASE_HZ=30 -> en[0] intervals 4,3,3 repeating; exactly 30 ticks per 100 cycles.
- Defaults, speed 0→3 mid-run -> interval drops from 100 to 12/13 cycles, en[1] alternation preserved across the switch.
- pause for 37 cycles mid-interval -> no en; next tick lands exactly 37 cycles later than unpaused reference.
- resync pulse with pause high, then pause released -> all en high ceil(CLK_HZ/inc) cycles after release.
- reset_n low during an en pulse -> en drops immediately; after release tick_cnt=0, first tick fires all channels.

Source files
------------

// File: rtl/clk_en_gen_pkg.sv
// Shared types and sizing helpers for the clock-enable generator.
// Honours CLK_EN_FAST_FORWARD_EN: when undefined the 8x width term drops out of acc_width.
package clk_en_pkg;

  typedef enum logic [1:0] {
    SPEED_1X = 2'd0,
    SPEED_2X = 2'd1,
    SPEED_4X = 2'd2,
    SPEED_8X = 2'd3
  } speed_t;

  localparam int unsigned MAX_SPEED_SHIFT = 3;

`ifdef CLK_EN_FAST_FORWARD_EN
  localparam int unsigned ACTIVE_SPEED_SHIFT = MAX_SPEED_SHIFT;
`else
  localparam int unsigned ACTIVE_SPEED_SHIFT = 0;
`endif

  // The accumulator never exceeds CLK_HZ - 1 plus the largest increment.
  function automatic int unsigned acc_width(input longint unsigned clk_hz,
                                            input longint unsigned base_hz);
    longint unsigned max_val;
    int unsigned     width;
    max_val = clk_hz + (base_hz << ACTIVE_SPEED_SHIFT) - 64'd1;
    width   = 1;
    for (int i = 1; i < 64; i++) begin
      if ((max_val >> i) != 64'd0) width = i + 1;
    end
    return width;
  endfunction

  function automatic int unsigned speed_shift(input speed_t sel);
    int unsigned sh;
    case (sel)
      SPEED_2X: sh = 1;
      SPEED_4X: sh = 2;
      SPEED_8X: sh = 3;
      default:  sh = 0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/clk_en_gen_frac_tick.sv
// Phase accumulator producing the fractional-rate base tick (combinational, one cycle wide).
// Speed multiplier active only when CLK_EN_FAST_FORWARD_EN is defined.
module frac_tick
  import clk_en_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 32'd6553600,
  parameter int unsigned BASE_HZ = 32'd65536,
  parameter int          ACC_W   = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pause,
  input  logic       resync,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam logic [ACC_W-1:0] BASE_INC = ACC_W'(BASE_HZ);
  localparam logic [ACC_W-1:0] LIMIT    = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] sum;

`ifdef CLK_EN_FAST_FORWARD_EN
  speed_t speed_sel;
  assign speed_sel = speed_t'(speed);
  assign inc       = BASE_INC << speed_shift(speed_sel);
`else
  logic [1:0] unused_speed;
  assign unused_speed = speed;
  assign inc          = BASE_INC;
`endif

  // Resync beats pause; pause freezes the phase exactly where it is.
  always_comb begin
    sum      = acc + inc;
    acc_next = acc;
    tick     = 1'b0;
    if (resync) begin
      acc_next = '0;
    end else if (!pause) begin
      if (sum >= LIMIT) begin
        acc_next = sum - LIMIT;
        tick     = 1'b1;
      end else begin
        acc_next = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc <= '0;
    else          acc <= acc_next;
  end

endmodule

// File: rtl/clk_en_gen.sv
// Clock-enable generator: base tick from frac_tick fanned out into power-of-two sub-rate enables.
// Optional fast-forward speed select via CLK_EN_FAST_FORWARD_EN (needs CLK_HZ >= 16*BASE_HZ at 8x).
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 32'd6553600,
  parameter int unsigned BASE_HZ = 32'd65536,
  parameter int          NUM_CH  = 2,
  parameter int          ACC_W   = 32,
  localparam int         CNT_W   = (NUM_CH > 1) ? NUM_CH - 1 : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pause,
  input  logic              resync,
  input  logic [1:0]        speed,
  output logic [NUM_CH-1:0] en,
  output logic [CNT_W-1:0]  tick_cnt
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("clk_en_gen: NUM_CH must be at least 1");
  end

  if (ACC_W < int'(acc_width(64'(CLK_HZ), 64'(BASE_HZ)))) begin : g_bad_acc_w
    $error("clk_en_gen: ACC_W too narrow for CLK_HZ and the largest increment");
  end

  logic              base_tick;
  logic [NUM_CH-1:0] en_next;
  logic [CNT_W-1:0]  cnt_next;

  frac_tick #(
    .CLK_HZ  (CLK_HZ),
    .BASE_HZ (BASE_HZ),
    .ACC_W   (ACC_W)
  ) u_frac_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .pause   (pause),
    .resync  (resync),
    .speed   (speed),
    .tick    (base_tick)
  );

  // Channel i fires on every 2^i-th base tick, all channels aligned at tick_cnt == 0.
  always_comb begin
    en_next  = '0;
    cnt_next = tick_cnt;
    if (resync) begin
      cnt_next = '0;
    end else if (base_tick) begin
      en_next[0] = 1'b1;
      for (int i = 1; i < NUM_CH; i++) begin
        en_next[i] = ((tick_cnt & CNT_W'((1 << i) - 1)) == '0);
      end
      if (NUM_CH > 1) cnt_next = tick_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en       <= '0;
      tick_cnt <= '0;
    end else begin
      en       <= en_next;
      tick_cnt <= cnt_next;
    end
  end

  a_no_back_to_back: assert property (@(posedge clk) disable iff (!reset_n) en[0] |=> !en[0]);

endmodule
